// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - header/slot byte sequencer feeding a UART transmitter.
// Define FRAME_CSUM_EN to append an 8-bit sum of the slot bytes to each frame.
module frame_sequencer #(
  parameter int N_CH     = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_req,
  input  logic       tx_busy,
  input  logic [7:0] enc_data,
  output logic       start,
  output logic [3:0] sel,
  output logic       tx_load,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       frame_done,
  output logic       err
);

  localparam int             CW        = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CW-1:0]  TO_LAST   = CW'(WAIT_MAX - 1);
  localparam logic [3:0]     LAST_SLOT = 4'(N_CH - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, SLOT, CSUM, WAIT_B, WAIT_I, DONE
  } state_t;

  state_t        state_q, state_d;
  state_t        last_q, last_d;     // byte state that issued the load in flight
  logic [3:0]    sel_q, sel_d;       // doubles as the slot counter
  logic          pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef FRAME_CSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  assign sel = sel_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= IDLE;
      sel_q   <= 4'd0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef FRAME_CSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
`ifdef FRAME_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
`ifdef FRAME_CSUM_EN
    csum_d     = csum_q;
`endif
    start      = 1'b0;
    tx_load    = 1'b0;
    tx_data    = 8'h00;
    frame_done = 1'b0;
    err        = 1'b0;
    busy       = (state_q != IDLE);

    // One-deep request queue; a second request while one is pending is lost.
    if (frame_req && busy) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        sel_d = 4'd0;
        if (frame_req || pend_q) begin
          state_d = HDR;
          pend_d  = 1'b0;
`ifdef FRAME_CSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      HDR: begin
        start = 1'b1;
        if (!tx_busy) begin
          tx_load = 1'b1;
          tx_data = enc_data;
          last_d  = HDR;
          cnt_d   = '0;
          state_d = WAIT_B;
        end
      end
      SLOT: begin
        if (!tx_busy) begin
          tx_load = 1'b1;
          tx_data = enc_data;
          last_d  = SLOT;
          cnt_d   = '0;
          state_d = WAIT_B;
`ifdef FRAME_CSUM_EN
          csum_d  = csum_q + enc_data;
`endif
        end
      end
`ifdef FRAME_CSUM_EN
      CSUM: begin
        if (!tx_busy) begin
          tx_load = 1'b1;
          tx_data = csum_q;
          last_d  = CSUM;
          cnt_d   = '0;
          state_d = WAIT_B;
        end
      end
`endif
      WAIT_B: begin
        if (tx_busy) begin
          state_d = WAIT_I;
        end else if (cnt_q == TO_LAST) begin
          // Transmitter never acknowledged; drop the frame but keep pending.
          err     = 1'b1;
          sel_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_I: begin
        if (!tx_busy) begin
          if (last_q == HDR) begin
            sel_d   = 4'd0;
            state_d = SLOT;
          end else if (last_q == SLOT && sel_q != LAST_SLOT) begin
            sel_d   = sel_q + 4'd1;
            state_d = SLOT;
          end else if (last_q == SLOT) begin
`ifdef FRAME_CSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        sel_d      = 4'd0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - scoreboard bench for frame_sequencer.
module tb_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_req = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] enc_data;
  logic       start;
  logic [3:0] sel;
  logic       tx_load;
  logic [7:0] tx_data;
  logic       busy;
  logic       frame_done;
  logic       err;

  always #5 clk = ~clk;

  frame_sequencer #(.N_CH(4), .WAIT_MAX(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_req  (frame_req),
    .tx_busy    (tx_busy),
    .enc_data   (enc_data),
    .start      (start),
    .sel        (sel),
    .tx_load    (tx_load),
    .tx_data    (tx_data),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  logic [7:0] slot_b [0:3] = '{8'h01, 8'h02, 8'h30, 8'hC8};
  assign enc_data = start ? 8'hFF : slot_b[sel[1:0]];

  typedef struct packed {
    logic [7:0] d;
    logic       st;
    logic [3:0] s;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int n_errp = 0;
  int last_done_cyc = -100;
  int last_hdr_cyc = -100;
  int err_cyc = -100;
  bit gap_chk = 1'b0;
  bit prev_done = 1'b0;
  bit tx_en = 1'b1;
  bit load_seen = 1'b0;
  int busy_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: event not seen within budget", name);
  endtask

  task automatic push(input logic [7:0] d, input logic st, input logic [3:0] s);
    exp_t e;
    e.d = d; e.st = st; e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic push_frame();
    push(8'hFF, 1'b1, 4'd0);
    push(8'h01, 1'b0, 4'd0);
    push(8'h02, 1'b0, 4'd1);
    push(8'h30, 1'b0, 4'd2);
    push(8'hC8, 1'b0, 4'd3);
`ifdef FRAME_CSUM_EN
    push(8'hFB, 1'b0, 4'd3);
`endif
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_req();
    step();
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (n_done < target && t < 400) begin
      step();
      t++;
    end
    chk("done_count", n_done, target);
  endtask

  task automatic wait_load(input logic [3:0] s);
    int t = 0;
    while (!(tx_load && !start && sel == s) && t < 300) begin
      step();
      t++;
    end
    if (t >= 300) fail("wait_slot_load");
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_tx_load"}, tx_load, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter model: busy for 3 cycles starting the cycle after a load.
  initial forever begin
    @(posedge clk);
    #1;
    if (load_seen) begin
      load_seen = 1'b0;
      if (tx_en) busy_left = 3;
    end
    if (busy_left > 0) begin
      tx_busy = 1'b1;
      busy_left--;
    end else begin
      tx_busy = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every load and tracks frame_done/err events.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (tx_load) begin
      load_seen = 1'b1;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_load: got tx_data=%0h with empty scoreboard", tx_data);
      end else begin
        e = exp_q.pop_front();
        chk("tx_data", tx_data, e.d);
        chk("start", start, e.st);
        chk("sel", sel, e.s);
        chk("busy_at_load", busy, 1);
        if (start) begin
          if (gap_chk) begin
            chk("hdr_gap", cyc - last_done_cyc, 2);
            gap_chk = 1'b0;
          end
          last_hdr_cyc = cyc;
        end
      end
    end
    if (frame_done) begin
      chk("done_width", prev_done, 0);
      n_done++;
      last_done_cyc = cyc;
    end
    prev_done = frame_done;
    if (err) begin
      n_errp++;
      err_cyc = cyc;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    // Reset state
    reset = 1'b0;
    repeat (3) step();
    chk_zero("reset");
    reset = 1'b1;

    // Basic frame
    push_frame();
    pulse_req();
    wait_done(1);
    step();
    chk("basic_busy_after", busy, 0);
    chk("basic_queue_empty", exp_q.size(), 0);

    // Pending: requests in slot 2 and slot 3 yield exactly one extra frame
    push_frame();
    push_frame();
    pulse_req();
    wait_load(4'd2);
    frame_req = 1'b1;
    gap_chk = 1'b1;
    step();
    frame_req = 1'b0;
    wait_load(4'd3);
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    wait_done(3);
    repeat (40) step();
    chk("pending_done_total", n_done, 3);
    chk("pending_queue_empty", exp_q.size(), 0);
    chk("pending_busy_after", busy, 0);

    // Timeout: transmitter never raises busy after the header
    tx_en = 1'b0;
    push(8'hFF, 1'b1, 4'd0);
    pulse_req();
    t = 0;
    while (n_errp < 1 && t < 100) begin
      step();
      t++;
    end
    chk("timeout_err_count", n_errp, 1);
    chk("timeout_latency", err_cyc - last_hdr_cyc, 15);
    step();
    chk("timeout_busy_after", busy, 0);
    chk("timeout_no_done", n_done, 3);
    chk("timeout_queue_empty", exp_q.size(), 0);
    tx_en = 1'b1;
    repeat (5) step();

    // Reset during WAIT_I of slot 1
    push(8'hFF, 1'b1, 4'd0);
    push(8'h01, 1'b0, 4'd0);
    push(8'h02, 1'b0, 4'd1);
    pulse_req();
    wait_load(4'd1);
    step();
    step();
    reset = 1'b0;
    step();
    chk_zero("midreset");
    reset = 1'b1;
    chk("midreset_queue_empty", exp_q.size(), 0);
    repeat (5) step();
    chk("midreset_no_done", n_done, 3);
    push_frame();
    pulse_req();
    wait_done(4);
    repeat (10) step();
    chk("midreset_err_count", n_errp, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 The module SHALL have parameter N_CH, default 4, meaning the number of channel slots per frame (legal range 1..16).
REQ-002 The module SHALL have parameter WAIT_MAX, default 15, meaning the number of cycles allowed for tx_busy to rise after tx_load.
REQ-003 Port clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset.
REQ-005 Port frame_req  input  1  single-cycle request to send one frame.
REQ-006 Port tx_busy  input  1  UART transmitter busy; a load is accepted only while it is 0.
REQ-007 Port enc_data  input  8  encoded byte from the protocol encoder for the current start/sel.
REQ-008 Port start  output  1  header-select to the encoder; 1 = emit frame-start byte 0xFF.
REQ-009 Port sel  output  4  channel index to the channel mux feeding the encoder.
REQ-010 Port tx_load  output  1  one-cycle load strobe to the UART transmitter.
REQ-011 Port tx_data  output  8  byte to transmit; valid when tx_load=1.
REQ-012 Port busy  output  1  1 while a frame is in progress.
REQ-013 Port frame_done  output  1  one-cycle pulse after the last byte of a frame is accepted by the transmitter.
REQ-014 Port err  output  1  one-cycle pulse on transmitter handshake timeout.

Function
REQ-015 The module SHALL implement states IDLE, HDR, SLOT, CSUM, WAIT_B, WAIT_I and DONE.
REQ-016 In IDLE with frame_req=1 or pending=1, the module SHALL go to HDR next cycle, clear pending and clear the checksum accumulator.
REQ-017 In HDR, start SHALL be 1, and tx_load=1 with tx_data=enc_data SHALL be issued in the first HDR cycle with tx_busy=0.
REQ-018 In SLOT, start SHALL be 0, sel SHALL equal the slot index 0..N_CH-1, and tx_load SHALL be issued under the same tx_busy=0 rule.
REQ-019 Every byte load SHALL be followed by WAIT_B (wait for tx_busy=1), then WAIT_I (wait for tx_busy=0), then the next byte state.
REQ-020 Slot order SHALL be 0 to N_CH-1; after the last slot completes, the next state SHALL be CSUM if enabled, else DONE.
REQ-021 DONE SHALL last exactly one cycle, pulse frame_done, and return to IDLE.
REQ-022 A frame SHALL be exactly 1 header byte plus N_CH slot bytes, with 1 extra byte when the checksum is enabled.
REQ-023 tx_load SHALL be exactly 1 cycle wide, and at most one tx_load SHALL occur per byte.
REQ-024 frame_req while busy=1 SHALL set a one-deep pending flag; further requests SHALL be dropped.
REQ-025 frame_req in the DONE cycle SHALL also set pending, so the next frame's HDR starts 2 cycles after DONE.
REQ-026 In WAIT_B, if tx_busy stays 0 for WAIT_MAX consecutive cycles, the module SHALL pulse err, abort to IDLE without frame_done, and preserve pending.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 sel SHALL hold its last value outside SLOT, and be 0 in IDLE and HDR.

Reset
REQ-029 With reset=0 at a clock edge, the state SHALL be IDLE and all outputs 0.
REQ-030 The same reset SHALL clear pending, the slot counter, the timeout counter and the checksum accumulator.
REQ-031 Reset mid-frame SHALL abandon the frame at once, with no frame_done, no err and no further tx_load.

Configuration
REQ-032 Macro FRAME_CSUM_EN SHALL control whether the checksum feature is compiled in.
REQ-033 With FRAME_CSUM_EN defined, the module SHALL accumulate the 8-bit wrap-around sum of the slot bytes (header excluded).
REQ-034 With FRAME_CSUM_EN defined, the CSUM state SHALL send that sum as tx_data, with start=0 and the same handshake rules.
REQ-035 Without FRAME_CSUM_EN, the CSUM state and the accumulator SHALL be absent and frames SHALL have N_CH+1 bytes.

Verification
REQ-036 Frame basic: N_CH=4, csum off, slot bytes 0x01,0x02,0x30,0xC8, TX busy 3 cycles per byte -> tx_data sequence FF,01,02,30,C8, then one frame_done pulse.
REQ-037 Checksum: FRAME_CSUM_EN, same stimulus -> sixth byte 0xFB (0x01+0x02+0x30+0xC8 mod 256).
REQ-038 Pending: frame_req in slot 2 and again in slot 3 -> exactly 2 frames, second HDR 2 cycles after first frame_done.
REQ-039 Timeout: tx_busy held 0 after the header load -> err pulse WAIT_MAX=15 cycles later, return to IDLE, no frame_done.
REQ-040 Reset mid-frame: reset=0 during WAIT_I of slot 1 -> next cycle all outputs 0, then a new frame_req gives a full frame starting 0xFF.
